gen_source_sequencer: RTL and testbench

//   Selects which test-signal generator (sinus / EKG 50 / EKG 55 / EKG 60) drives the

---
 rtl/gen_source_sequencer_if.sv | 25 ++
 rtl/gen_source_sequencer.sv | 137 +++++++++++++
 tb/tb_gen_source_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gen_source_sequencer_if.sv
// rtl/gen_source_sequencer_if.sv - switch/codec/generator bus for the source sequencer
interface gen_source_sequencer_if #(
    parameter int W = 24
);
    logic [3:0]   sw;
    logic         sample_ready;
    logic [W-1:0] src0;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [W-1:0] src3;
    logic [W-1:0] dac_data;
    logic [1:0]   sel_active;
    logic         muted;
    logic         busy;

    modport master (
        output sw, sample_ready, src0, src1, src2, src3,
        input  dac_data, sel_active, muted, busy
    );

    modport slave (
        input  sw, sample_ready, src0, src1, src2, src3,
        output dac_data, sel_active, muted, busy
    );
endinterface

// File: rtl/gen_source_sequencer.sv
// rtl/gen_source_sequencer.sv - debounced source select with click-free gain ramp mute
module gen_source_sequencer #(
    parameter int W          = 24,
    parameter int GAIN_W     = 8,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gen_source_sequencer_if.slave bus
);
    localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [GAIN_W:0]  UNITY   = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]  ZERO    = '0;

    typedef enum logic [1:0] {
        S_MUTE,
        S_RAMP_UP,
        S_PLAY,
        S_RAMP_DOWN
    } state_t;

    state_t           state_q, state_d;
    logic [GAIN_W:0]  gain_q, gain_d;
    logic [1:0]       sel_q, sel_d;
    logic [W-1:0]     dac_q, dac_d;
    logic [3:0]       sw_q, sw_stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             tick;
    logic             tgt_valid;
    logic [1:0]       tgt_idx;
    logic             target_match;
    logic [W-1:0]     src_sel;
    logic [W+GAIN_W+1:0] prod;

    // Accept a new switch pattern only after it has held for DEB_CYCLES equal cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_q        <= '0;
            sw_stable_q <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
        end else begin
            sw_q    <= bus.sw;
            ready_q <= bus.sample_ready;
            if (bus.sw != sw_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                sw_stable_q <= sw_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tick = bus.sample_ready & ~ready_q;

    always_comb begin
        tgt_valid = 1'b0;
        tgt_idx   = 2'd0;
        case (sw_stable_q)
            4'b0001: begin tgt_valid = 1'b1; tgt_idx = 2'd0; end
            4'b0010: begin tgt_valid = 1'b1; tgt_idx = 2'd1; end
            4'b0100: begin tgt_valid = 1'b1; tgt_idx = 2'd2; end
            4'b1000: begin tgt_valid = 1'b1; tgt_idx = 2'd3; end
            default: begin tgt_valid = 1'b0; tgt_idx = 2'd0; end
        endcase
    end

    assign target_match = tgt_valid && (tgt_idx == sel_q);

    // Gain steps follow the current state's direction; the new state applies from the next tick.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        sel_d   = sel_q;
        case (state_q)
            S_MUTE: begin
                gain_d = ZERO;
                if (tgt_valid) begin
                    sel_d   = tgt_idx;
                    state_d = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (tick && gain_q != UNITY) gain_d = gain_q + 1'b1;
                if (!target_match)         state_d = S_RAMP_DOWN;
                else if (gain_d == UNITY)  state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!target_match) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (tick && gain_q != ZERO) gain_d = gain_q - 1'b1;
                if (target_match)          state_d = S_RAMP_UP;
                else if (gain_d == ZERO)   state_d = S_MUTE;
            end
            default: begin
                state_d = S_MUTE;
                gain_d  = ZERO;
            end
        endcase
    end

    always_comb begin
        case (sel_q)
            2'd0:    src_sel = bus.src0;
            2'd1:    src_sel = bus.src1;
            2'd2:    src_sel = bus.src2;
            default: src_sel = bus.src3;
        endcase
    end

    // Sign-extended operands so the low product bits are the exact signed product.
    assign prod  = {{(GAIN_W+2){src_sel[W-1]}}, src_sel} * {{W{1'b0}}, 1'b0, gain_q};
    assign dac_d = W'($signed(prod) >>> GAIN_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_MUTE;
            gain_q  <= '0;
            sel_q   <= '0;
            dac_q   <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            sel_q   <= sel_d;
            if (tick) dac_q <= dac_d;
        end
    end

    assign bus.dac_data   = dac_q;
    assign bus.sel_active = sel_q;
    assign bus.muted      = (state_q == S_MUTE);
    assign bus.busy       = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
endmodule

// File: tb/tb_gen_source_sequencer.sv
// tb/tb_gen_source_sequencer.sv - scoreboard bench for gen_source_sequencer
module tb_gen_source_sequencer;
    localparam int W     = 24;
    localparam int GW    = 2;
    localparam int DEB   = 4;
    localparam int UNITY = 4;
    localparam int SETTLE = DEB + 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gen_source_sequencer_if #(.W(W)) bus ();

    gen_source_sequencer #(.W(W), .GAIN_W(GW), .DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] dac;
        logic [1:0]   sel;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;

    longint m_src[4];
    int     m_gain, m_sel, m_target;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [W-1:0] scale(input longint s, input int g);
        longint p, q;
        p = s * g;
        q = p / UNITY;
        if ((p % UNITY) != 0 && p < 0) q = q - 1;
        return q[W-1:0];
    endfunction

    // A silent channel may be re-pointed at the requested source.
    task automatic model_settle();
        if (m_gain == 0 && m_target >= 0) m_sel = m_target;
    endtask

    task automatic check_status();
        bit exp_muted, exp_busy;
        exp_muted = (m_gain == 0) && (m_target < 0);
        exp_busy  = !exp_muted && !((m_gain == UNITY) && (m_target == m_sel));
        check("muted", longint'(bus.muted), longint'(exp_muted));
        check("busy", longint'(bus.busy), longint'(exp_busy));
        check("sel_active", longint'(bus.sel_active), longint'(m_sel));
    endtask

    task automatic set_sw(input logic [3:0] v, input int hold, input bit settle);
        @(negedge clk);
        bus.sw = v;
        repeat (hold) @(negedge clk);
        if (settle) begin
            m_target = decode(v);
            model_settle();
            check_status();
        end
    endtask

    task automatic drive_src();
        bus.src0 = m_src[0][W-1:0];
        bus.src1 = m_src[1][W-1:0];
        bus.src2 = m_src[2][W-1:0];
        bus.src3 = m_src[3][W-1:0];
    endtask

    task automatic do_tick(input int width);
        exp_t e;
        int goal;
        @(negedge clk);
        drive_src();
        bus.sample_ready = 1'b1;
        e.dac = scale(m_src[m_sel], m_gain);
        e.sel = 2'(m_sel);
        sb.push_back(e);
        goal = (m_target == m_sel) ? UNITY : 0;
        if (m_gain < goal)      m_gain++;
        else if (m_gain > goal) m_gain--;
        model_settle();
        repeat (width) @(negedge clk);
        bus.sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_status();
    endtask

    logic rdy_prev, tick_seen;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_prev  <= 1'b0;
            tick_seen <= 1'b0;
        end else begin
            tick_seen <= bus.sample_ready & ~rdy_prev;
            rdy_prev  <= bus.sample_ready;
        end
    end

    always @(negedge clk) begin
        if (tick_seen) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_tick: dac %0d with empty scoreboard", $signed(bus.dac_data));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dac_data", longint'($signed(bus.dac_data)), longint'($signed(e.dac)));
                check("tick_sel", longint'(bus.sel_active), longint'(e.sel));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] old_sw, v;
        int r;
        bus.sw = 4'b0000;
        bus.sample_ready = 1'b0;
        m_src[0] = 4000; m_src[1] = 0; m_src[2] = -4000; m_src[3] = 0;
        drive_src();
        m_gain = 0; m_sel = 0; m_target = -1;
        repeat (3) @(negedge clk);
        check("reset_dac", longint'($signed(bus.dac_data)), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_status();

        // Ramp up on src0, glitch ignored, swap to src2, reversal mid ramp-down.
        set_sw(4'b0001, SETTLE, 1'b1);
        repeat (6) do_tick(1);
        set_sw(4'b0010, 3, 1'b0);
        set_sw(4'b0001, SETTLE, 1'b1);
        do_tick(1);
        set_sw(4'b0100, SETTLE, 1'b1);
        repeat (9) do_tick(1);
        set_sw(4'b0001, SETTLE, 1'b1);
        repeat (2) do_tick(1);
        set_sw(4'b0100, SETTLE, 1'b1);
        repeat (3) do_tick(1);

        // Floor on negative product and a long ready level counted once.
        set_sw(4'b0001, SETTLE, 1'b1);
        repeat (5) do_tick(1);
        m_src[0] = -3;
        do_tick(1);
        do_tick(10);
        do_tick(1);

        // Asynchronous reset mid-ramp, observed before any clock edge.
        set_sw(4'b0100, SETTLE, 1'b1);
        do_tick(1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_dac", longint'($signed(bus.dac_data)), 0);
        check("async_rst_muted", longint'(bus.muted), 1);
        check("async_rst_busy", longint'(bus.busy), 0);
        bus.sw = 4'b0000;
        m_gain = 0; m_sel = 0; m_target = -1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        set_sw(4'b0000, SETTLE, 1'b1);

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                v = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                set_sw(v, SETTLE, 1'b1);
            end else if (r == 3) begin
                old_sw = bus.sw;
                v = 4'($urandom_range(0, 15));
                set_sw(v, $urandom_range(1, DEB - 1), 1'b0);
                set_sw(old_sw, SETTLE, 1'b1);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        m_src[k] = longint'($urandom_range(0, 15)) - 8;
                    else
                        m_src[k] = longint'($urandom_range(0, 1048575)) - 524288;
                end
                repeat ($urandom_range(1, 5)) do_tick($urandom_range(1, 4));
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
